// File: rtl/shake_absorb_stream.sv
// rtl/shake_absorb_stream.sv - streaming SHAKE128/256 absorber driving an external Keccak-f[1600] unit
// Define SHAKE_ABSORB_FINALIZE_EN to include the SHAKE padding (PAD) stage.
module shake_absorb_stream #(
  parameter int IN_BYTES = 8,
  localparam int DBW = $clog2(IN_BYTES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rtr,
  input  logic                  mode,
  input  logic [1599:0]         state_in,
  input  logic [31:0]           pos_in,
  input  logic [8*IN_BYTES-1:0] din,
  input  logic [DBW-1:0]        din_bytes,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic                  din_ready,
  input  logic                  finalize,
  output logic                  perm_req,
  output logic [1599:0]         perm_state_out,
  input  logic [1599:0]         perm_state_in,
  input  logic                  perm_ack,
  output logic [1599:0]         state_out,
  output logic [31:0]           pos_out,
  output logic                  rts
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ABSORB = 3'd1;
  localparam logic [2:0] S_PERM   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef SHAKE_ABSORB_FINALIZE_EN
  localparam logic [2:0] S_PAD    = 3'd3;
`endif

  logic [2:0]            fsm_q, fsm_d;
  logic [1599:0]         st_q, st_d;
  logic [7:0]            pos_q, pos_d;
  logic                  mode_q, mode_d;
  logic                  fin_q, fin_d;
  logic [8*IN_BYTES-1:0] lo_data_q, lo_data_d;
  logic [DBW-1:0]        lo_cnt_q, lo_cnt_d;
  logic                  lo_last_q, lo_last_d;
  logic                  last_done_q, last_done_d;
  logic [1599:0]         state_out_q, state_out_d;
  logic [7:0]            pos_out_q, pos_out_d;

  logic [7:0] rate, rate_in;
  logic [2:0] after_last;

  assign rate    = mode_q ? 8'd168 : 8'd136;
  assign rate_in = mode ? 8'd168 : 8'd136;

`ifdef SHAKE_ABSORB_FINALIZE_EN
  assign after_last = fin_q ? S_PAD : S_DONE;
`else
  logic unused_fin;
  assign after_last = S_DONE;
  assign unused_fin = fin_q;
`endif

  assign din_ready      = (fsm_q == S_ABSORB) && (lo_cnt_q == '0);
  assign perm_req       = (fsm_q == S_PERM);
  assign perm_state_out = st_q;
  assign rts            = (fsm_q == S_DONE);
  assign state_out      = state_out_q;
  assign pos_out        = {24'd0, pos_out_q};

  always_comb begin
    logic [8*IN_BYTES-1:0] src_data;
    logic [DBW-1:0]        src_cnt;
    logic                  src_last;
    logic                  take;
    int                    pos_i;
    int                    n_i;
    int                    rem_i;

    fsm_d       = fsm_q;
    st_d        = st_q;
    pos_d       = pos_q;
    mode_d      = mode_q;
    fin_d       = fin_q;
    lo_data_d   = lo_data_q;
    lo_cnt_d    = lo_cnt_q;
    lo_last_d   = lo_last_q;
    last_done_d = last_done_q;
    state_out_d = state_out_q;
    pos_out_d   = pos_out_q;

    // Buffered leftover bytes always take priority over a new beat.
    if (lo_cnt_q != '0) begin
      src_data = lo_data_q;
      src_cnt  = lo_cnt_q;
      src_last = lo_last_q;
      take     = 1'b1;
    end else begin
      src_data = din;
      src_cnt  = din_bytes;
      src_last = din_last;
      take     = din_valid;
    end
    pos_i = int'(pos_q);
    n_i   = int'(rate) - pos_i;
    if (int'(src_cnt) < n_i) n_i = int'(src_cnt);
    rem_i = int'(src_cnt) - n_i;

    case (fsm_q)
      S_IDLE: begin
        if (rtr) begin
          st_d        = state_in;
          pos_d       = pos_in[7:0];
          mode_d      = mode;
          fin_d       = finalize;
          lo_cnt_d    = '0;
          lo_last_d   = 1'b0;
          last_done_d = 1'b0;
          fsm_d       = (pos_in == {24'd0, rate_in}) ? S_PERM : S_ABSORB;
        end
      end
      S_ABSORB: begin
        if (take) begin
          for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < IN_BYTES; k++) begin
              if (k < n_i && i == pos_i + k) st_d[8*i +: 8] = st_d[8*i +: 8] ^ src_data[8*k +: 8];
            end
          end
          pos_d     = pos_q + n_i[7:0];
          lo_data_d = src_data >> (8 * n_i);
          lo_cnt_d  = rem_i[DBW-1:0];
          lo_last_d = src_last;
          if (pos_d == rate) begin
            fsm_d       = S_PERM;
            last_done_d = src_last && (rem_i == 0);
          end else if (src_last && rem_i == 0) begin
            fsm_d = after_last;
          end
        end
      end
      S_PERM: begin
        if (perm_ack) begin
          st_d        = perm_state_in;
          pos_d       = 8'd0;
          last_done_d = 1'b0;
          fsm_d       = last_done_q ? after_last : S_ABSORB;
        end
      end
`ifdef SHAKE_ABSORB_FINALIZE_EN
      S_PAD: begin
        // 0x1F and 0x80 merge into 0x9F when pos is the last rate byte.
        for (int i = 0; i < 200; i++) begin
          if (i == pos_i) st_d[8*i +: 8] = st_d[8*i +: 8] ^ 8'h1F;
          if (i == int'(rate) - 1) st_d[8*i +: 8] = st_d[8*i +: 8] ^ 8'h80;
        end
        pos_d = rate;
        fsm_d = S_DONE;
      end
`endif
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase

    if (fsm_d == S_DONE && fsm_q != S_DONE) begin
      state_out_d = st_d;
      pos_out_d   = pos_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q       <= S_IDLE;
      st_q        <= '0;
      pos_q       <= '0;
      mode_q      <= 1'b0;
      fin_q       <= 1'b0;
      lo_data_q   <= '0;
      lo_cnt_q    <= '0;
      lo_last_q   <= 1'b0;
      last_done_q <= 1'b0;
      state_out_q <= '0;
      pos_out_q   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      pos_q       <= pos_d;
      mode_q      <= mode_d;
      fin_q       <= fin_d;
      lo_data_q   <= lo_data_d;
      lo_cnt_q    <= lo_cnt_d;
      lo_last_q   <= lo_last_d;
      last_done_q <= last_done_d;
      state_out_q <= state_out_d;
      pos_out_q   <= pos_out_d;
    end
  end

endmodule

// File: tb/tb_shake_absorb_stream.sv
// tb/tb_shake_absorb_stream.sv - scoreboard bench for shake_absorb_stream with a modelled permutation unit
module tb_shake_absorb_stream;
  localparam int IN_BYTES = 8;
  localparam int DBW = 4;
`ifdef SHAKE_ABSORB_FINALIZE_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic clock, reset, rtr, mode, din_valid, din_last, din_ready, finalize;
  logic perm_req, perm_ack, rts;
  logic [1599:0] state_in, perm_state_out, perm_state_in, state_out;
  logic [31:0] pos_in, pos_out;
  logic [8*IN_BYTES-1:0] din;
  logic [DBW-1:0] din_bytes;

  typedef logic [7:0] msg_t [$];
  typedef struct { logic [1599:0] st; logic [31:0] pos; } exp_t;
  exp_t exp_q [$];

  int checks = 0;
  int errors = 0;
  int perm_cnt = 0;
  int ready_in_perm = 0;
  logic perm_req_prev = 1'b0;
  int perm_lat_cfg = 3;
  int resp_lat;

  shake_absorb_stream #(.IN_BYTES(IN_BYTES)) dut (
    .clock(clock), .reset(reset), .rtr(rtr), .mode(mode), .state_in(state_in), .pos_in(pos_in),
    .din(din), .din_bytes(din_bytes), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .finalize(finalize), .perm_req(perm_req), .perm_state_out(perm_state_out),
    .perm_state_in(perm_state_in), .perm_ack(perm_ack), .state_out(state_out), .pos_out(pos_out), .rts(rts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [1599:0] fake_perm(input logic [1599:0] s);
    return {s[1591:0], s[1599:1592]} ^ {50{32'h5A3C_96E1}};
  endfunction

  function automatic int first_diff(input logic [1599:0] a, input logic [1599:0] b);
    for (int i = 0; i < 200; i++) if (a[8*i +: 8] !== b[8*i +: 8]) return i;
    return 0;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom();
    return s;
  endfunction

  // Permutation unit: answers each request after a configurable latency.
  initial begin
    perm_ack = 1'b0;
    perm_state_in = '0;
    forever begin
      @(negedge clock);
      if (perm_req === 1'b1) begin
        resp_lat = (perm_lat_cfg == 0) ? int'($urandom_range(24, 1)) : perm_lat_cfg;
        repeat (resp_lat - 1) @(negedge clock);
        if (perm_req === 1'b1) begin
          perm_state_in = fake_perm(perm_state_out);
          perm_ack = 1'b1;
          @(negedge clock);
          perm_ack = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    perm_req_prev <= perm_req;
    if (perm_req && !perm_req_prev) perm_cnt <= perm_cnt + 1;
    if (perm_req && din_ready) ready_in_perm <= ready_in_perm + 1;
  end

  task automatic model_run(input logic m, input logic [1599:0] s_in, input int p_in, input logic fin,
                           input msg_t msg, output exp_t e);
    logic [1599:0] s;
    int p, rate;
    rate = m ? 168 : 136;
    s = s_in;
    p = p_in;
    foreach (msg[j]) begin
      if (p == rate) begin s = fake_perm(s); p = 0; end
      s[8*p +: 8] = s[8*p +: 8] ^ msg[j];
      p++;
    end
    if (p == rate) begin s = fake_perm(s); p = 0; end
    if (PAD_EN && fin) begin
      s[8*p +: 8] = s[8*p +: 8] ^ 8'h1F;
      s[8*(rate-1) +: 8] = s[8*(rate-1) +: 8] ^ 8'h80;
      p = rate;
    end
    e.st = s;
    e.pos = p;
  endtask

  task automatic drive_op(input logic m, input logic [1599:0] s_in, input int p_in, input logic fin,
                          input msg_t msg, input int beat, input bit gaps);
    exp_t e;
    int idx, n, to;
    model_run(m, s_in, p_in, fin, msg, e);
    exp_q.push_back(e);
    @(posedge clock); #1;
    rtr = 1'b1; mode = m; state_in = s_in; pos_in = p_in; finalize = fin;
    @(posedge clock); #1;
    rtr = 1'b0; mode = ~m; state_in = '0; pos_in = 0; finalize = ~fin;
    idx = 0;
    while (idx < msg.size()) begin
      n = (beat == 0) ? int'($urandom_range(IN_BYTES, 1)) : beat;
      if (n > msg.size() - idx) n = msg.size() - idx;
      if (gaps && $urandom_range(3, 0) == 0) begin din_valid = 1'b0; @(posedge clock); #1; end
      din = '0;
      for (int k = 0; k < n; k++) din[8*k +: 8] = msg[idx + k];
      din_bytes = DBW'(n);
      din_last = (idx + n == msg.size());
      din_valid = 1'b1;
      to = 0;
      forever begin
        @(negedge clock);
        if (din_ready) break;
        to++;
        if (to > 500) break;
      end
      if (to > 500) begin
        checks++; errors++;
        $display("FAIL beat_accept: din_ready low for 500 cycles at byte %0d, required high", idx);
        din_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
      idx += n;
    end
    din_valid = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic wait_rts(input int budget, output int cyc, output bit seen);
    cyc = 0;
    seen = 1'b0;
    while (cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (rts) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int bad_rts, bad_out;
    bad_rts = 0; bad_out = 0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (rts !== 1'b0) bad_rts++;
      if (din_ready !== 1'b0 || perm_req !== 1'b0 || state_out !== '0 || pos_out !== 0 || perm_state_out !== '0) bad_out++;
    end
    checks++; if (bad_rts !== 0) begin errors++; $display("FAIL reset_rts: %0d rts cycles, required 0", bad_rts); end
    checks++; if (bad_out !== 0) begin errors++; $display("FAIL reset_outputs: %0d nonzero cycles, required 0", bad_out); end
    checks++; if (pos_out !== 32'd0) begin errors++; $display("FAIL reset_pos: got %0d required 0", pos_out); end
    checks++; if (state_out !== '0) begin errors++; $display("FAIL reset_state: byte %0d nonzero, required 0", first_diff(state_out, '0)); end
  endtask

  task automatic test_single_beat();
    msg_t msg;
    exp_t e;
    int cyc, p0, d;
    bit seen;
    for (int i = 1; i <= 8; i++) msg.push_back(8'(i));
    perm_lat_cfg = 3;
    p0 = perm_cnt;
    drive_op(1'b0, '0, 0, 1'b1, msg, 8, 1'b0);
    wait_rts(50, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL single_rts: no rts in 50 cycles, required rts"); end
    checks++; if (cyc !== (PAD_EN ? 2 : 1)) begin errors++; $display("FAIL single_latency: rts after %0d cycles, required %0d", cyc, PAD_EN ? 2 : 1); end
    checks++; if (perm_cnt - p0 !== 0) begin errors++; $display("FAIL single_perm: %0d requests, required 0", perm_cnt - p0); end
    checks++; if (state_out[71:0] !== {(PAD_EN ? 8'h1F : 8'h00), 64'h0807060504030201})
      begin errors++; $display("FAIL single_bytes0_8: got %h required %h", state_out[71:0], {(PAD_EN ? 8'h1F : 8'h00), 64'h0807060504030201}); end
    checks++; if (state_out[1087:1080] !== (PAD_EN ? 8'h80 : 8'h00)) begin errors++; $display("FAIL single_byte135: got %h required %h", state_out[1087:1080], PAD_EN ? 8'h80 : 8'h00); end
    checks++; if (pos_out !== (PAD_EN ? 32'd136 : 32'd8)) begin errors++; $display("FAIL single_pos: got %0d required %0d", pos_out, PAD_EN ? 136 : 8); end
    checks++; if (state_out !== e.st) begin errors++; d = first_diff(state_out, e.st); $display("FAIL single_state: byte %0d got %h required %h", d, state_out[8*d +: 8], e.st[8*d +: 8]); end
  endtask

  task automatic test_cross_rate();
    msg_t msg;
    exp_t e;
    int cyc, p0, d;
    bit seen;
    for (int i = 0; i < 8; i++) msg.push_back(8'($urandom()));
    perm_lat_cfg = 3;
    p0 = perm_cnt;
    drive_op(1'b1, rand_state(), 164, 1'b0, msg, 8, 1'b0);
    wait_rts(60, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL cross_rts: no rts in 60 cycles, required rts"); end
    checks++; if (perm_cnt - p0 !== 1) begin errors++; $display("FAIL cross_perm: %0d requests, required 1", perm_cnt - p0); end
    checks++; if (pos_out !== 32'd4) begin errors++; $display("FAIL cross_pos: got %0d required 4", pos_out); end
    checks++; if (state_out !== e.st) begin errors++; d = first_diff(state_out, e.st); $display("FAIL cross_state: byte %0d got %h required %h", d, state_out[8*d +: 8], e.st[8*d +: 8]); end
  endtask

  task automatic test_pad_last_byte();
    msg_t msg;
    exp_t e;
    int cyc, d;
    bit seen;
    msg.push_back(8'hAA);
    drive_op(1'b0, '0, 134, 1'b1, msg, 1, 1'b0);
    wait_rts(20, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL padlast_rts: no rts in 20 cycles, required rts"); end
    checks++; if (state_out[1079:1072] !== 8'hAA) begin errors++; $display("FAIL padlast_byte134: got %h required aa", state_out[1079:1072]); end
    checks++; if (state_out[1087:1080] !== (PAD_EN ? 8'h9F : 8'h00)) begin errors++; $display("FAIL padlast_byte135: got %h required %h", state_out[1087:1080], PAD_EN ? 8'h9F : 8'h00); end
    checks++; if (pos_out !== (PAD_EN ? 32'd136 : 32'd135)) begin errors++; $display("FAIL padlast_pos: got %0d required %0d", pos_out, PAD_EN ? 136 : 135); end
    checks++; if (state_out !== e.st) begin errors++; d = first_diff(state_out, e.st); $display("FAIL padlast_state: byte %0d got %h required %h", d, state_out[8*d +: 8], e.st[8*d +: 8]); end
  endtask

  task automatic test_stream_272();
    msg_t msg;
    exp_t e;
    int cyc, p0, r0, d;
    bit seen;
    for (int i = 0; i < 272; i++) msg.push_back(8'($urandom()));
    perm_lat_cfg = 0;
    p0 = perm_cnt;
    r0 = ready_in_perm;
    drive_op(1'b0, rand_state(), 0, 1'b1, msg, 8, 1'b1);
    wait_rts(200, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL stream_rts: no rts in 200 cycles, required rts"); end
    checks++; if (perm_cnt - p0 !== 2) begin errors++; $display("FAIL stream_perm: %0d requests, required 2", perm_cnt - p0); end
    checks++; if (ready_in_perm - r0 !== 0) begin errors++; $display("FAIL stream_ready_in_perm: %0d cycles, required 0", ready_in_perm - r0); end
    checks++; if (pos_out !== e.pos) begin errors++; $display("FAIL stream_pos: got %0d required %0d", pos_out, e.pos); end
    checks++; if (state_out !== e.st) begin errors++; d = first_diff(state_out, e.st); $display("FAIL stream_state: byte %0d got %h required %h", d, state_out[8*d +: 8], e.st[8*d +: 8]); end
  endtask

  task automatic test_leftover();
    msg_t msg;
    exp_t e;
    int cyc, d, r0;
    bit seen;
    for (int i = 0; i < 300; i++) msg.push_back(8'($urandom()));
    perm_lat_cfg = 0;
    r0 = ready_in_perm;
    drive_op(1'b1, rand_state(), int'($urandom_range(167, 0)), 1'($urandom()), msg, 0, 1'b1);
    wait_rts(200, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL leftover_rts: no rts in 200 cycles, required rts"); end
    checks++; if (pos_out !== e.pos) begin errors++; $display("FAIL leftover_pos: got %0d required %0d", pos_out, e.pos); end
    checks++; if (state_out !== e.st) begin errors++; d = first_diff(state_out, e.st); $display("FAIL leftover_state: byte %0d got %h required %h", d, state_out[8*d +: 8], e.st[8*d +: 8]); end
    checks++; if (ready_in_perm - r0 !== 0) begin errors++; $display("FAIL leftover_ready_in_perm: %0d cycles, required 0", ready_in_perm - r0); end
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(8'($urandom()));
    drive_op(1'b0, rand_state(), 136, 1'b0, msg, 0, 1'b0);
    wait_rts(100, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL fullstart_rts: no rts in 100 cycles, required rts"); end
    checks++; if (pos_out !== 32'd5) begin errors++; $display("FAIL fullstart_pos: got %0d required 5", pos_out); end
    checks++; if (state_out !== e.st) begin errors++; d = first_diff(state_out, e.st); $display("FAIL fullstart_state: byte %0d got %h required %h", d, state_out[8*d +: 8], e.st[8*d +: 8]); end
  endtask

  task automatic test_reset_mid();
    msg_t msg;
    exp_t e;
    int cyc, d, to;
    bit seen;
    for (int i = 0; i < 8; i++) msg.push_back(8'($urandom()));
    perm_lat_cfg = 24;
    drive_op(1'b0, rand_state(), 130, 1'b0, msg, 8, 1'b0);
    void'(exp_q.pop_front());
    to = 0;
    while (perm_req !== 1'b1 && to < 50) begin @(negedge clock); to++; end
    checks++; if (perm_req !== 1'b1) begin errors++; $display("FAIL rstperm_reach: perm_req %b, required 1", perm_req); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if ({din_ready, perm_req, rts} !== 3'b000 || perm_state_out !== '0 || state_out !== '0 || pos_out !== 0)
      begin errors++; $display("FAIL rstperm_outputs: ready %b req %b rts %b pos %0d, required all 0", din_ready, perm_req, rts, pos_out); end
    reset = 1'b1;
    repeat (30) @(negedge clock);
    perm_lat_cfg = 0;
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom()));
    drive_op(1'b1, rand_state(), 160, 1'b1, msg, 0, 1'b1);
    wait_rts(100, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL rstclean_rts: no rts in 100 cycles, required rts"); end
    checks++; if (state_out !== e.st || pos_out !== e.pos) begin errors++; d = first_diff(state_out, e.st); $display("FAIL rstclean_result: byte %0d got %h required %h pos %0d required %0d", d, state_out[8*d +: 8], e.st[8*d +: 8], pos_out, e.pos); end
    msg.delete();
    msg.push_back(8'h5C); msg.push_back(8'hE3);
    drive_op(1'b0, '0, 0, 1'b0, msg, 2, 1'b0);
    wait_rts(20, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen || state_out[15:0] !== 16'hE35C) begin errors++; $display("FAIL rstdone_before: rts %b bytes %h, required rts 1 bytes e35c", seen, state_out[15:0]); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if ({din_ready, perm_req, rts} !== 3'b000 || state_out !== '0 || pos_out !== 0)
      begin errors++; $display("FAIL rstdone_outputs: ready %b req %b rts %b pos %0d, required all 0", din_ready, perm_req, rts, pos_out); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    drive_op(1'b0, '0, 10, 1'b0, msg, 1, 1'b0);
    wait_rts(20, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen || state_out !== e.st || pos_out !== 32'd12) begin errors++; d = first_diff(state_out, e.st); $display("FAIL rstdone_clean: rts %b byte %0d got %h required %h pos %0d required 12", seen, d, state_out[8*d +: 8], e.st[8*d +: 8], pos_out); end
  endtask

  initial begin
    rtr = 1'b0; mode = 1'b0; state_in = '0; pos_in = 0; din = '0; din_bytes = '0;
    din_valid = 1'b0; din_last = 1'b0; finalize = 1'b0; reset = 1'b0;
    test_reset();
    test_single_beat();
    test_cross_rate();
    test_pad_last_byte();
    test_stream_272();
    test_leftover();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
